// File: rtl/lib_cpu_pkg.sv
// Shared CPU definitions: interrupt FSM states, default vector base and the
// vector-address helper used by the interrupt controller.
package lib_cpu;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TAKE    = 2'd1,
    SERVICE = 2'd2
  } INTR_STATE;

  localparam logic [31:0] INTR_VEC_BASE = 32'h0000_0100;

  // Vector address of a source; 32-bit arithmetic, wraps modulo 2^32.
  function automatic logic [31:0] intr_vec_addr(input logic [31:0] base,
                                                input logic [4:0]  id,
                                                input int unsigned stride);
    return base + (32'(id) * 32'(stride));
  endfunction

endpackage

// File: rtl/prio_enc.sv
// Lowest-index-wins priority encoder, purely combinational.
// Shared between the interrupt controller and the bus arbiter.
module prio_enc #(
  parameter int N = 8
) (
  input  logic [N-1:0] i_req,
  output logic         o_valid,
  output logic [4:0]   o_idx
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_valid = 1'b1;
        o_idx   = 5'(i);
      end
    end
  end

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller: rising-edge capture of sources into a pending
// register, software mask, fixed-priority arbitration and a three-state
// IDLE/TAKE/SERVICE sequencer that issues a one-cycle redirect request and
// holds the in-service level until the handler returns.
//
// Handshake: the consumer deasserts stall to say it can accept a redirect in
// the next cycle. A take is only decided in IDLE with stall=0; the resulting
// irq_take pulse (one cycle, TAKE state) must then be accepted unconditionally
// because stall is not looked at again in TAKE.
module intr_ctrl
  import lib_cpu::*;
#(
  parameter int          N_SRC      = 8,
  parameter logic [31:0] VEC_BASE   = INTR_VEC_BASE,
  parameter int          VEC_STRIDE = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_SRC-1:0] src,
  input  logic             intr_en,
  input  logic             stall,
  input  logic             iret,
  input  logic             mask_we,
  input  logic [N_SRC-1:0] mask_wdata,
  output logic [N_SRC-1:0] pend,
  output logic [N_SRC-1:0] mask,
  output logic             irq_take,
  output logic [4:0]       irq_id,
  output logic [31:0]      irq_vec,
  output logic             irr,
  output INTR_STATE        dbg_state
);

  INTR_STATE        r_state;
  logic [N_SRC-1:0] r_src_q;
  logic [N_SRC-1:0] r_pend;
  logic [N_SRC-1:0] r_mask;
  logic [4:0]       r_irq_id;

  logic [N_SRC-1:0] w_rise;
  logic [N_SRC-1:0] w_elig;
  logic             w_win_valid;
  logic [4:0]       w_win_idx;
  logic             w_take_go;
  logic [N_SRC-1:0] w_clr;
  logic [N_SRC-1:0] w_pend_nxt;

  assign w_rise = src & ~r_src_q;
  assign w_elig = r_pend & r_mask;

  prio_enc #(
    .N(N_SRC)
  ) u_prio_enc (
    .i_req  (w_elig),
    .o_valid(w_win_valid),
    .o_idx  (w_win_idx)
  );

  // The decision uses the mask as it stands this cycle; a write in the same
  // cycle only lands at the edge.
  assign w_take_go = (r_state == IDLE) && w_win_valid && intr_en && !stall;

  // A new rise on the bit being taken re-sets it: set beats clear.
  assign w_clr      = w_take_go ? (N_SRC'(1) << w_win_idx) : '0;
  assign w_pend_nxt = (r_pend & ~w_clr) | w_rise;

  // State, pending, mask, source history and winning id.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_src_q  <= '0;
      r_pend   <= '0;
      r_mask   <= '0;
      r_irq_id <= '0;
    end else begin
      r_src_q <= src;
      r_pend  <= w_pend_nxt;
      if (mask_we) begin
        r_mask <= mask_wdata;
      end
      case (r_state)
        IDLE: begin
          if (w_take_go) begin
            r_state  <= TAKE;
            r_irq_id <= w_win_idx;
          end
        end
        TAKE:    r_state <= SERVICE;
        SERVICE: begin
          if (iret) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign pend      = r_pend;
  assign mask      = r_mask;
  assign irq_id    = r_irq_id;
  assign irq_take  = (r_state == TAKE);
  assign irr       = (r_state == TAKE) || (r_state == SERVICE);
  assign irq_vec   = intr_vec_addr(VEC_BASE, r_irq_id, VEC_STRIDE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_intr_ctrl.sv
// Bench for intr_ctrl: directed scenarios with literal expectations, then
// randomized traffic, all checked every cycle against a behavioural model.
module tb_intr_ctrl;

  logic        clk;
  logic        reset_n;
  logic [7:0]  src;
  logic        intr_en;
  logic        stall;
  logic        iret;
  logic        mask_we;
  logic [7:0]  mask_wdata;
  logic [7:0]  pend;
  logic [7:0]  mask;
  logic        irq_take;
  logic [4:0]  irq_id;
  logic [31:0] irq_vec;
  logic        irr;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  intr_ctrl #(
    .N_SRC     (8),
    .VEC_BASE  (32'h0000_0100),
    .VEC_STRIDE(4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .src       (src),
    .intr_en   (intr_en),
    .stall     (stall),
    .iret      (iret),
    .mask_we   (mask_we),
    .mask_wdata(mask_wdata),
    .pend      (pend),
    .mask      (mask),
    .irq_take  (irq_take),
    .irq_id    (irq_id),
    .irq_vec   (irq_vec),
    .irr       (irr),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The model tracks "a take fires this cycle" and "a handler is running"
  // as two plain flags, and applies the rules edge by edge.
  logic [7:0] m_pend, m_mask, m_prev;
  int         m_id;
  bit         m_take, m_busy, m_valid;

  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return -1;
  endfunction

  initial begin
    m_pend = 0; m_mask = 0; m_prev = 0; m_id = 0;
    m_take = 0; m_busy = 0; m_valid = 0;
  end

  always @(posedge clk) begin
    logic [7:0] rise, clr;
    if (!reset_n) begin
      m_pend = 0; m_mask = 0; m_prev = 0; m_id = 0;
      m_take = 0; m_busy = 0; m_valid = 1;
    end else begin
      rise = src & ~m_prev;
      clr  = 8'h00;
      if (m_take) begin
        m_take = 0;
        m_busy = 1;
      end else if (m_busy) begin
        if (iret) m_busy = 0;
      end else if ((m_pend & m_mask) != 0 && intr_en && !stall) begin
        m_id   = lowest(m_pend & m_mask);
        clr[m_id] = 1'b1;
        m_take = 1;
      end
      m_pend = (m_pend & ~clr) | rise;
      if (mask_we) m_mask = mask_wdata;
      m_prev = src;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(posedge clk) begin
    #1;
    if (m_valid) begin
      chk("pend",     32'(pend),     32'(m_pend));
      chk("mask",     32'(mask),     32'(m_mask));
      chk("irq_take", 32'(irq_take), 32'(m_take));
      chk("irr",      32'(irr),      32'(m_take | m_busy));
      chk("irq_id",   32'(irq_id),   32'(m_id));
      chk("irq_vec",  irq_vec,       32'h100 + 32'(m_id) * 32'd4);
    end
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic iret_pulse();
    iret = 1'b1;
    tick();
    iret = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int takes;
    reset_n = 0; src = 8'hFF; intr_en = 0; stall = 0; iret = 0;
    mask_we = 1; mask_wdata = 8'hFF;
    repeat (3) tick();

    // Reset state
    chk("rst_take", 32'(irq_take), 32'd0);
    chk("rst_irr",  32'(irr),      32'd0);
    chk("rst_vec",  irq_vec,       32'h100);
    chk("rst_pend", 32'(pend),     32'd0);
    chk("rst_mask", 32'(mask),     32'd0);
    chk("rst_id",   32'(irq_id),   32'd0);
    src = 8'h00; mask_we = 0; reset_n = 1;
    tick();

    // Single request on source 3
    mask_we = 1; mask_wdata = 8'h08; intr_en = 1;
    tick();
    mask_we = 0; src = 8'h08;
    tick();
    chk("single_pend", 32'(pend), 32'h08);
    chk("single_notake_yet", 32'(irq_take), 32'd0);
    tick();
    chk("single_take", 32'(irq_take), 32'd1);
    chk("single_id",   32'(irq_id),   32'd3);
    chk("single_vec",  irq_vec,       32'h10C);
    chk("single_pend_clr", 32'(pend), 32'h00);
    tick();
    chk("single_take_1cyc", 32'(irq_take), 32'd0);
    chk("single_irr_hold",  32'(irr),      32'd1);
    src = 8'h00;
    repeat (3) tick();
    chk("single_irr_wait", 32'(irr), 32'd1);
    iret_pulse();
    chk("single_irr_drop", 32'(irr), 32'd0);

    // Priority and masking
    mask_we = 1; mask_wdata = 8'hF0;
    tick();
    mask_we = 0; src = 8'h22;
    tick();
    tick();
    chk("prio_take", 32'(irq_take), 32'd1);
    chk("prio_id",   32'(irq_id),   32'd5);
    chk("prio_masked_pend", 32'(pend), 32'h02);
    src = 8'h00;
    tick();
    iret_pulse();
    mask_we = 1; mask_wdata = 8'hFF;
    tick();
    chk("prio_same_cycle_write", 32'(irq_take), 32'd0);
    mask_we = 0;
    tick();
    chk("prio_unmask_take", 32'(irq_take), 32'd1);
    chk("prio_unmask_vec",  irq_vec,       32'h104);
    tick();
    iret_pulse();

    // Gating by intr_en and stall
    intr_en = 0; src = 8'h01;
    tick();
    src = 8'h00;
    takes = 0;
    repeat (10) begin tick(); if (irq_take) takes++; end
    intr_en = 1; stall = 1;
    repeat (3) begin tick(); if (irq_take) takes++; end
    chk("gate_no_take", 32'(takes), 32'd0);
    chk("gate_pend_held", 32'(pend), 32'h01);
    stall = 0;
    tick();
    chk("gate_take", 32'(irq_take), 32'd1);
    chk("gate_id",   32'(irq_id),   32'd0);
    tick();
    iret_pulse();

    // Set/clear collision and no nesting
    stall = 1; src = 8'h04;
    tick();
    src = 8'h00;
    tick();
    stall = 0; src = 8'h04;
    tick();
    chk("coll_take", 32'(irq_take), 32'd1);
    chk("coll_id",   32'(irq_id),   32'd2);
    chk("coll_pend", 32'(pend),     32'h04);
    src = 8'h00;
    tick();
    src = 8'h01;
    tick();
    src = 8'h00;
    tick();
    chk("nest_pend", 32'(pend), 32'h05);
    chk("nest_take", 32'(irq_take), 32'd0);
    iret_pulse();
    chk("b2b_idle_gap", 32'(irr), 32'd0);
    tick();
    chk("b2b_first_take", 32'(irq_take), 32'd1);
    chk("b2b_first_id",   32'(irq_id),   32'd0);
    tick();
    iret_pulse();
    chk("b2b_idle_gap2", 32'(irr), 32'd0);
    tick();
    chk("b2b_second_take", 32'(irq_take), 32'd1);
    chk("b2b_second_id",   32'(irq_id),   32'd2);
    tick();
    iret_pulse();

    // Reset in the middle of a service
    src = 8'h10;
    tick();
    src = 8'h00;
    tick();
    tick();
    src = 8'h80;
    tick();
    src = 8'h00;
    chk("mid_pend", 32'(pend), 32'h80);
    chk("mid_irr",  32'(irr),  32'd1);
    reset_n = 0;
    tick();
    chk("mid_rst_irr",  32'(irr),  32'd0);
    chk("mid_rst_pend", 32'(pend), 32'h00);
    reset_n = 1;
    takes = 0;
    repeat (5) begin tick(); if (irq_take) takes++; end
    chk("mid_no_take", 32'(takes), 32'd0);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) src = src ^ (8'($urandom) & 8'($urandom));
      mask_we    = ($urandom_range(0, 15) == 0);
      mask_wdata = 8'($urandom);
      intr_en    = ($urandom_range(0, 7) != 0);
      stall      = ($urandom_range(0, 4) == 0);
      iret       = ($urandom_range(0, 3) == 0);
      reset_n    = ($urandom_range(0, 499) != 0);
      tick();
    end
    reset_n = 1; iret = 0; mask_we = 0;
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/intr_ctrl.md
# intr_ctrl

Interrupt controller feeding the special-register stage. Edge-detects `N_SRC` external interrupt sources into a pending register and applies a software mask plus the global `intr_en` from the execute stage. It arbitrates by fixed priority and issues a one-cycle take request with a vector address to the fetch/redirect logic. It also drives the `irr` level that the special-register file latches, holding it until the handler returns.

## Interface
Parameters:
- `N_SRC`, 8, number of interrupt sources (1..32)
- `VEC_BASE`, 32'h0000_0100, vector address of source 0
- `VEC_STRIDE`, 4, byte distance between consecutive vectors (power of two)

Ports:
- `clk`  in  1  single clock; all logic on posedge
- `reset_n`  in  1  synchronous, active-low reset
- `src`  in  N_SRC  interrupt request lines, already synchronous to `clk`
- `intr_en`  in  1  global enable from execute stage
- `stall`  in  1  pipeline cannot accept a redirect this cycle
- `iret`  in  1  one-cycle pulse: handler return retired
- `mask_we`  in  1  write strobe for mask register
- `mask_wdata`  in  N_SRC  new mask value (1 = enabled)
- `pend`  out  N_SRC  pending register (readable status)
- `mask`  out  N_SRC  mask register
- `irq_take`  out  1  one-cycle redirect request
- `irq_id`  out  5  winning source index, valid with `irq_take` and held through service
- `irq_vec`  out  32  `VEC_BASE + irq_id*VEC_STRIDE`, valid with `irq_take`
- `irr`  out  1  in-service flag, to special-register file

## Operation
- Edge detect: `src_q` holds the previous `src`. Rise on bit i = `src[i] & ~src_q[i]` sets `pend[i]`.
- A level held high does not re-trigger.
- Eligible set: `pend & mask`. Winner: lowest set index.
- FSM states: IDLE, TAKE, SERVICE.
  - IDLE→TAKE when eligible set ≠ 0, `intr_en`=1, and `stall`=0. At this transition:
    - register `irq_id`;
    - clear `pend[irq_id]`.
  - TAKE→SERVICE unconditionally after one cycle. `irq_take`=1 only while in TAKE.
  - SERVICE→IDLE on `iret`. `irr`=1 in TAKE and in SERVICE.
- While in TAKE or SERVICE, no new take occurs (no nesting). Pending bits continue to accumulate.
- Set/clear collision: if a rise on bit i coincides with clearing `pend[i]` on take, the set wins and `pend[i]` stays 1.
- A `mask_we` write takes effect at the next edge. A write in the same cycle as the IDLE decision does not affect that decision.
- Masking a bit does not clear its pending state.
- `iret` outside SERVICE is ignored.
- `irq_vec` width rule: the computation is done in 32 bits and wraps modulo 2^32.

## Timing
- Reset (`reset_n`=0 at an edge):
  - state=IDLE;
  - `pend`, `mask`, `src_q`, `irq_id` = 0;
  - `irq_take`=0, `irr`=0;
  - `irq_vec` = `VEC_BASE`.
- Reset takes priority over every other event, including mid-service. Outstanding pending requests are lost.
- Latency from a source rise to take:
  - `src[i]` sampled 1 (with `src_q[i]`=0) at edge k → `pend[i]`=1 after edge k;
  - IDLE decision evaluated in cycle k→k+1 → TAKE after edge k+1;
  - `irq_take` high for the single cycle between edges k+1 and k+2.
- `irr` rises after edge k+1 and falls after the edge that samples `iret`=1.
- `stall` or `intr_en`=0 during IDLE only delays the take. Pending state is held.
- `stall` is not sampled in TAKE: the consumer must accept `irq_take` whenever it has deasserted `stall` the cycle before.
- Back-to-back: with a second source pending, a take can occur at the earliest at the edge after the IDLE return, giving one IDLE cycle between services.

## Structure
- Shared package `lib_cpu`:
  - `INTR_STATE` enum (IDLE, TAKE, SERVICE);
  - `INTR_VEC_BASE` default constant.
- Sub-module `prio_enc` (parameterised N-input lowest-index priority encoder). Outputs `valid` and a 5-bit index; purely combinational, reused by the bus arbiter.
- Single `always_ff` for state/`pend`/`mask`/`irq_id`; outputs decoded from state.

## Test plan
- Reset: hold `reset_n`=0 with `src`=8'hFF and `mask_wdata`=8'hFF with `mask_we`=1 → all outputs 0, `irq_vec`=32'h100, `pend`=0.
- Single request: mask=8'h08, `intr_en`=1, `src[3]` rises at edge k → `irq_take`=1 in cycle k+1..k+2 only, `irq_id`=3, `irq_vec`=32'h10C, `irr`=1 until `iret`, `pend[3]`=0.
- Priority and masking: mask=8'hF0, `src`=8'h22 rises → `irq_id`=5 (bit 1 masked stays pending). After `iret`, write mask=8'hFF → bit 1 taken with `irq_vec`=32'h104.
- Gating: pending bit 0 with `intr_en`=0 for 10 cycles, then `stall`=1 for 3 cycles → no `irq_take`. Take occurs on the first cycle both `intr_en`=1 and `stall`=0.
- Collision/no-nest: `src[2]` re-rises in the cycle of its take, and `src[0]` rises in SERVICE → `pend`=8'h05 during service. After `iret`, `irq_id`=0 then 2, each with `irr` pulse separated by one IDLE cycle.
- Reset mid-service: `reset_n`=0 while in SERVICE with `pend`=8'h80 → next cycle IDLE, `irr`=0, `pend`=0, no `irq_take` after release.
